// File: rtl/bfly_r2_stage.sv
// Radix-2 DIF butterfly stage: emits the sum blocks as pairs arrive, then replays
// the buffered difference blocks back-to-back for the twiddle multiplier.
module bfly_r2_stage #(
  parameter int unsigned DATA_WIDTH = 9,
  parameter int unsigned LANES      = 16,
  parameter int unsigned BLOCKS     = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              bfly_en,
  input  logic [DATA_WIDTH*LANES-1:0]       a_i,
  input  logic [DATA_WIDTH*LANES-1:0]       a_q,
  input  logic [DATA_WIDTH*LANES-1:0]       b_i,
  input  logic [DATA_WIDTH*LANES-1:0]       b_q,
  output logic [(DATA_WIDTH+1)*LANES-1:0]   dout_i,
  output logic [(DATA_WIDTH+1)*LANES-1:0]   dout_q,
  output logic                              dout_valid,
  output logic                              dout_phase,
  output logic                              frame_done,
  output logic                              busy,
  output logic                              err_overrun
);

  localparam int unsigned OW = DATA_WIDTH + 1;
  localparam int unsigned VW = OW * LANES;
  localparam int unsigned CW = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;

  typedef enum logic [1:0] {IDLE, SUM, DIFF} state_t;

  state_t           state, state_n;
  logic [CW-1:0]    pair_cnt, pair_n;
  logic [CW-1:0]    rd_cnt, rd_n;
  logic             wr_en;
  logic [VW-1:0]    sum_i, sum_q, dif_i, dif_q;
  logic [VW-1:0]    dout_i_n, dout_q_n;
  logic             valid_n, phase_n, frame_n, err_n;
  logic [2*VW-1:0]  dbuf [BLOCKS];
  logic [2*VW-1:0]  rd_word;

  // Per-lane exact add/subtract on sign-extended operands.
  always_comb begin : arith
    logic [OW-1:0] ai, aq, bi, bq;
    sum_i = '0;
    sum_q = '0;
    dif_i = '0;
    dif_q = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      ai = {a_i[l*DATA_WIDTH + DATA_WIDTH-1], a_i[l*DATA_WIDTH +: DATA_WIDTH]};
      aq = {a_q[l*DATA_WIDTH + DATA_WIDTH-1], a_q[l*DATA_WIDTH +: DATA_WIDTH]};
      bi = {b_i[l*DATA_WIDTH + DATA_WIDTH-1], b_i[l*DATA_WIDTH +: DATA_WIDTH]};
      bq = {b_q[l*DATA_WIDTH + DATA_WIDTH-1], b_q[l*DATA_WIDTH +: DATA_WIDTH]};
      sum_i[l*OW +: OW] = ai + bi;
      sum_q[l*OW +: OW] = aq + bq;
      dif_i[l*OW +: OW] = ai - bi;
      dif_q[l*OW +: OW] = aq - bq;
    end
  end

  assign rd_word = dbuf[rd_cnt];
  assign busy    = (state != IDLE);

  // Next-state and registered-output values.
  always_comb begin
    state_n  = state;
    pair_n   = pair_cnt;
    rd_n     = rd_cnt;
    wr_en    = 1'b0;
    dout_i_n = dout_i;
    dout_q_n = dout_q;
    valid_n  = 1'b0;
    phase_n  = dout_phase;
    frame_n  = 1'b0;
    err_n    = err_overrun;
    case (state)
      IDLE: begin
        if (bfly_en) begin
          wr_en    = 1'b1;
          dout_i_n = sum_i;
          dout_q_n = sum_q;
          valid_n  = 1'b1;
          phase_n  = 1'b0;
          if (BLOCKS == 1) begin
            state_n = DIFF;
            rd_n    = '0;
            pair_n  = '0;
          end else begin
            state_n = SUM;
            pair_n  = CW'(1);
          end
        end
      end
      SUM: begin
        if (bfly_en) begin
          wr_en    = 1'b1;
          dout_i_n = sum_i;
          dout_q_n = sum_q;
          valid_n  = 1'b1;
          phase_n  = 1'b0;
          if (pair_cnt == CW'(BLOCKS-1)) begin
            state_n = DIFF;
            rd_n    = '0;
            pair_n  = '0;
          end else begin
            pair_n = pair_cnt + CW'(1);
          end
        end
      end
      DIFF: begin
        dout_i_n = rd_word[2*VW-1:VW];
        dout_q_n = rd_word[VW-1:0];
        valid_n  = 1'b1;
        phase_n  = 1'b1;
        if (bfly_en) err_n = 1'b1;
        if (rd_cnt == CW'(BLOCKS-1)) begin
          state_n = IDLE;
          frame_n = 1'b1;
          rd_n    = '0;
          pair_n  = '0;
        end else begin
          rd_n = rd_cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      pair_cnt    <= '0;
      rd_cnt      <= '0;
      dout_i      <= '0;
      dout_q      <= '0;
      dout_valid  <= 1'b0;
      dout_phase  <= 1'b0;
      frame_done  <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      state       <= state_n;
      pair_cnt    <= pair_n;
      rd_cnt      <= rd_n;
      dout_i      <= dout_i_n;
      dout_q      <= dout_q_n;
      dout_valid  <= valid_n;
      dout_phase  <= phase_n;
      frame_done  <= frame_n;
      err_overrun <= err_n;
    end
  end

  // Difference buffer, indexed by pair number within the frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < int'(BLOCKS); k++) dbuf[k] <= '0;
    end else if (wr_en) begin
      dbuf[pair_cnt] <= {dif_i, dif_q};
    end
  end

endmodule

// File: tb/tb_bfly_r2_stage.sv
// Directed bench for bfly_r2_stage: table-driven frame vectors plus stall,
// overrun, mid-frame reset and back-to-back frame sequences.
module tb_bfly_r2_stage;

  localparam int unsigned DW = 9;
  localparam int unsigned L  = 16;
  localparam int unsigned B  = 16;
  localparam int unsigned OW = DW + 1;
  localparam int unsigned IW = DW * L;
  localparam int unsigned VW = OW * L;

  typedef struct {
    int a;
    int b;
    int s;
    int d;
  } vec_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          bfly_en = 1'b0;
  logic [IW-1:0] a_i = '0, a_q = '0, b_i = '0, b_q = '0;
  logic [VW-1:0] dout_i, dout_q;
  logic          dout_valid, dout_phase, frame_done, busy, err_overrun;

  int total = 0;
  int bad   = 0;

  vec_t          tbl [B];
  logic [IW-1:0] pa_i [B], pa_q [B], pb_i [B], pb_q [B];
  logic [VW-1:0] es_i [B], es_q [B], ed_i [B], ed_q [B];

  bfly_r2_stage #(.DATA_WIDTH(DW), .LANES(L), .BLOCKS(B)) dut (
    .clk(clk), .rstn(rstn), .bfly_en(bfly_en),
    .a_i(a_i), .a_q(a_q), .b_i(b_i), .b_q(b_q),
    .dout_i(dout_i), .dout_q(dout_q), .dout_valid(dout_valid),
    .dout_phase(dout_phase), .frame_done(frame_done), .busy(busy),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  // a = lane index, b = 1 on I; Q swaps roles (a = 1, b = lane index).
  task automatic load_lane_frame();
    for (int k = 0; k < int'(B); k++) begin
      for (int l = 0; l < int'(L); l++) begin
        pa_i[k][l*DW +: DW] = DW'(l);
        pb_i[k][l*DW +: DW] = DW'(1);
        pa_q[k][l*DW +: DW] = DW'(1);
        pb_q[k][l*DW +: DW] = DW'(l);
        es_i[k][l*OW +: OW] = OW'(l + 1);
        ed_i[k][l*OW +: OW] = OW'(l - 1);
        es_q[k][l*OW +: OW] = OW'(l + 1);
        ed_q[k][l*OW +: OW] = OW'(1 - l);
      end
    end
  endtask

  // Pair k broadcasts tbl[k] on I; Q swaps a and b so its diff is negated.
  task automatic load_table_frame();
    for (int k = 0; k < int'(B); k++) begin
      for (int l = 0; l < int'(L); l++) begin
        pa_i[k][l*DW +: DW] = DW'(tbl[k].a);
        pb_i[k][l*DW +: DW] = DW'(tbl[k].b);
        pa_q[k][l*DW +: DW] = DW'(tbl[k].b);
        pb_q[k][l*DW +: DW] = DW'(tbl[k].a);
        es_i[k][l*OW +: OW] = OW'(tbl[k].s);
        ed_i[k][l*OW +: OW] = OW'(tbl[k].d);
        es_q[k][l*OW +: OW] = OW'(tbl[k].s);
        ed_q[k][l*OW +: OW] = OW'(-tbl[k].d);
      end
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge showing the last block.
  task automatic run_frame(input bit stall, input bit extra, input int npairs);
    for (int k = 0; k < npairs; k++) begin
      if (stall && k > 0) begin
        bfly_en = 1'b0;
        @(negedge clk);
        chk1("stall_valid", dout_valid, 1'b0);
        chk("stall_hold_i", dout_i, es_i[k-1]);
      end
      bfly_en = 1'b1;
      a_i = pa_i[k]; a_q = pa_q[k]; b_i = pb_i[k]; b_q = pb_q[k];
      @(negedge clk);
      chk1("sum_valid", dout_valid, 1'b1);
      chk1("sum_phase", dout_phase, 1'b0);
      chk1("sum_frame_done", frame_done, 1'b0);
      chk("sum_i", dout_i, es_i[k]);
      chk("sum_q", dout_q, es_q[k]);
    end
    bfly_en = 1'b0;
    if (npairs >= int'(B)) begin
      for (int k = 0; k < int'(B); k++) begin
        bfly_en = extra && (k == 0);
        a_i = '1; a_q = '1; b_i = '0; b_q = '0;
        @(negedge clk);
        bfly_en = 1'b0;
        chk1("diff_valid", dout_valid, 1'b1);
        chk1("diff_phase", dout_phase, 1'b1);
        chk1("diff_frame_done", frame_done, k == int'(B) - 1);
        chk("diff_i", dout_i, ed_i[k]);
        chk("diff_q", dout_q, ed_q[k]);
      end
      chk1("end_busy", busy, 1'b0);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_dout_i"}, dout_i, '0);
    chk({nm, "_dout_q"}, dout_q, '0);
    chk1({nm, "_valid"}, dout_valid, 1'b0);
    chk1({nm, "_phase"}, dout_phase, 1'b0);
    chk1({nm, "_frame_done"}, frame_done, 1'b0);
    chk1({nm, "_busy"}, busy, 1'b0);
    chk1({nm, "_err"}, err_overrun, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{255, 255, 510, 0};
    tbl[1]  = '{-256, 255, -1, -511};
    tbl[2]  = '{-256, -256, -512, 0};
    tbl[3]  = '{255, -256, -1, 511};
    tbl[4]  = '{0, 0, 0, 0};
    tbl[5]  = '{1, -1, 0, 2};
    tbl[6]  = '{-1, -1, -2, 0};
    tbl[7]  = '{100, -50, 50, 150};
    tbl[8]  = '{-128, 127, -1, -255};
    tbl[9]  = '{127, 128, 255, -1};
    tbl[10] = '{-200, -56, -256, -144};
    tbl[11] = '{37, 200, 237, -163};
    tbl[12] = '{255, 0, 255, 255};
    tbl[13] = '{0, -256, -256, 256};
    tbl[14] = '{-1, 255, 254, -256};
    tbl[15] = '{64, 64, 128, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Gap-free lane-index frame, then idle hold check
    load_lane_frame();
    run_frame(1'b0, 1'b0, int'(B));
    bfly_en = 1'b0;
    @(negedge clk);
    chk1("idle_valid", dout_valid, 1'b0);
    chk1("idle_frame_done", frame_done, 1'b0);
    chk("idle_hold_i", dout_i, ed_i[B-1]);
    chk1("idle_err", err_overrun, 1'b0);

    // Width extremes and mixed-sign table
    load_table_frame();
    run_frame(1'b0, 1'b0, int'(B));
    @(negedge clk);

    // Stalls every other cycle in SUM
    run_frame(1'b1, 1'b0, int'(B));
    @(negedge clk);
    chk1("stall_err", err_overrun, 1'b0);

    // Overrun: 17th enable dropped, sticky error
    load_lane_frame();
    run_frame(1'b0, 1'b1, int'(B));
    chk1("overrun_err", err_overrun, 1'b1);
    repeat (3) @(negedge clk);
    chk1("overrun_err_sticky", err_overrun, 1'b1);

    // Reset mid-frame after 8 pairs
    run_frame(1'b0, 1'b0, 8);
    rstn = 1'b0;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    load_table_frame();
    run_frame(1'b0, 1'b0, int'(B));

    // Back-to-back frames
    load_lane_frame();
    run_frame(1'b0, 1'b0, int'(B));
    load_table_frame();
    run_frame(1'b0, 1'b0, int'(B));
    chk1("b2b_err", err_overrun, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
